// File: rtl/decode.sv
// RV32I instruction-decode pipeline stage: registers the fetched PC/instruction,
// produces decoded fields for execute and detects load-use hazards.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_ce,
  input  logic        stall,
  input  logic        flush,
  output logic        o_stall_decode,
  output logic [4:0]  o_rs1_raddr,
  output logic [4:0]  o_rs2_raddr,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_imm,
  output logic [2:0]  o_funct3,
  output logic        o_alt,
  output logic [10:0] o_opcode,
  output logic [3:0]  o_exception,
  output logic        o_ce
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr;
  logic        is_lui, is_auipc, is_sys, is_fence;
  logic        is_ecall, is_ebreak, is_mret;
  logic        bad_r, bad_load, bad_store, bad_branch, bad_sys, unknown, illegal;
  logic [10:0] opcode_d;
  logic        alt_d;
  logic [31:0] imm_d;
  logic        uses_rs1, uses_rs2;
  logic        stall_bit;

  assign opc = i_instr[6:0];
  assign f3  = i_instr[14:12];
  assign f7  = i_instr[31:25];

  assign is_r      = (opc == 7'b0110011);
  assign is_ialu   = (opc == 7'b0010011);
  assign is_load   = (opc == 7'b0000011);
  assign is_store  = (opc == 7'b0100011);
  assign is_branch = (opc == 7'b1100011);
  assign is_jal    = (opc == 7'b1101111);
  assign is_jalr   = (opc == 7'b1100111);
  assign is_lui    = (opc == 7'b0110111);
  assign is_auipc  = (opc == 7'b0010111);
  assign is_sys    = (opc == 7'b1110011);
  assign is_fence  = (opc == 7'b0001111);

  assign is_ecall  = (i_instr == 32'h0000_0073);
  assign is_ebreak = (i_instr == 32'h0010_0073);
  assign is_mret   = (i_instr == 32'h3020_0073);

  assign unknown = !(is_r | is_ialu | is_load | is_store | is_branch | is_jal |
                     is_jalr | is_lui | is_auipc | is_sys | is_fence);

  assign bad_r      = is_r && !((f7 == 7'h00) ||
                                ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
  assign bad_load   = is_load && ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  assign bad_store  = is_store && (f3 >= 3'b011);
  assign bad_branch = is_branch && ((f3 == 3'b010) || (f3 == 3'b011));
  assign bad_sys    = is_sys && ((f3 == 3'b100) ||
                                 ((f3 == 3'b000) && !(is_ecall | is_ebreak | is_mret)));

  assign illegal = (i_instr[1:0] != 2'b11) | unknown | bad_r | bad_load |
                   bad_store | bad_branch | bad_sys;

  assign opcode_d = illegal ? '0 :
                    {is_fence, is_sys, is_auipc, is_lui, is_jalr, is_jal,
                     is_branch, is_store, is_load, is_ialu, is_r};

  // Alternate-op bit only means something for SUB/SRA and SRAI
  assign alt_d = i_instr[30] & (opcode_d[0] | (opcode_d[1] && (f3 == 3'b101)));

  always_comb begin
    imm_d = '0;
    if (is_ialu || is_load || is_jalr)
      imm_d = {{20{i_instr[31]}}, i_instr[31:20]};
    else if (is_store)
      imm_d = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    else if (is_branch)
      imm_d = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
               i_instr[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm_d = {i_instr[31:12], 12'b0};
    else if (is_jal)
      imm_d = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
               i_instr[30:21], 1'b0};
  end

  assign uses_rs1 = opcode_d[0] | opcode_d[1] | opcode_d[2] | opcode_d[3] |
                    opcode_d[4] | opcode_d[6] | (opcode_d[9] && (f3 != 3'b000));
  assign uses_rs2 = opcode_d[0] | opcode_d[3] | opcode_d[4];

  assign o_rs1_raddr = i_instr[19:15];
  assign o_rs2_raddr = i_instr[24:20];

  // Hazard clears itself once the bubble drops o_ce
  assign o_stall_decode = i_ce && o_ce && o_opcode[2] && (o_rd_addr != 5'd0) &&
                          ((uses_rs1 && (i_instr[19:15] == o_rd_addr)) ||
                           (uses_rs2 && (i_instr[24:20] == o_rd_addr)));

  assign stall_bit = o_stall_decode | stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_pc        <= '0;
      o_rs1_addr  <= '0;
      o_rs2_addr  <= '0;
      o_rd_addr   <= '0;
      o_imm       <= '0;
      o_funct3    <= '0;
      o_alt       <= 1'b0;
      o_opcode    <= '0;
      o_exception <= '0;
      o_ce        <= 1'b0;
    end else begin
      if (i_ce && !stall_bit) begin
        o_pc        <= i_pc;
        o_rs1_addr  <= i_instr[19:15];
        o_rs2_addr  <= i_instr[24:20];
        o_rd_addr   <= i_instr[11:7];
        o_imm       <= imm_d;
        o_funct3    <= f3;
        o_alt       <= alt_d;
        o_opcode    <= opcode_d;
        o_exception <= {is_mret, is_ebreak, is_ecall, illegal};
      end
      if (!stall_bit)
        o_ce <= flush ? 1'b0 : i_ce;
      else if (o_stall_decode && !stall)
        o_ce <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage with hand-computed expectations.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst, i_ce, stall, flush;
  logic [31:0] i_pc, i_instr;
  logic        o_stall_decode, o_alt, o_ce;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [31:0] o_pc, o_imm;
  logic [2:0]  o_funct3;
  logic [10:0] o_opcode;
  logic [3:0]  o_exception;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr(i_instr), .i_ce(i_ce),
    .stall(stall), .flush(flush), .o_stall_decode(o_stall_decode),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr), .o_pc(o_pc),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_imm(o_imm), .o_funct3(o_funct3), .o_alt(o_alt), .o_opcode(o_opcode),
    .o_exception(o_exception), .o_ce(o_ce)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_ce = 1'b0; stall = 1'b0; flush = 1'b0;
    i_pc = '0; i_instr = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ce", o_ce, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_opcode", o_opcode, 0);
    chk("rst_imm", o_imm, 0);
    chk("rst_exc", o_exception, 0);
    chk("rst_rd", o_rd_addr, 0);
    chk("rst_stall", o_stall_decode, 0);

    // addi x1,x0,5
    i_ce = 1'b1; i_pc = 32'h0; i_instr = 32'h0050_0093;
    step();
    chk("addi_ce", o_ce, 1);
    chk("addi_opcode", o_opcode, 11'h002);
    chk("addi_rd", o_rd_addr, 1);
    chk("addi_rs1", o_rs1_addr, 0);
    chk("addi_imm", o_imm, 5);
    chk("addi_exc", o_exception, 0);

    // lw x2,0(x1) then add x3,x2,x1 -> one-cycle load-use stall then bubble
    i_pc = 32'h4; i_instr = 32'h0000_A103;
    step();
    chk("lw_opcode", o_opcode, 11'h004);
    chk("lw_rd", o_rd_addr, 2);
    chk("lw_funct3", o_funct3, 3'b010);
    i_pc = 32'h8; i_instr = 32'h0011_01B3;
    #1;
    chk("hz_stall", o_stall_decode, 1);
    chk("hz_raddr1", o_rs1_raddr, 2);
    chk("hz_raddr2", o_rs2_raddr, 1);
    step();
    chk("bub_ce", o_ce, 0);
    chk("bub_stall", o_stall_decode, 0);
    chk("bub_pc_hold", o_pc, 32'h4);
    chk("bub_rd_hold", o_rd_addr, 2);
    step();
    chk("add_ce", o_ce, 1);
    chk("add_opcode", o_opcode, 11'h001);
    chk("add_rs1", o_rs1_addr, 2);
    chk("add_rs2", o_rs2_addr, 1);
    chk("add_rd", o_rd_addr, 3);
    chk("add_pc", o_pc, 32'h8);

    // beq x1,x2,-8
    i_pc = 32'h100; i_instr = 32'hFE20_8CE3;
    step();
    chk("beq_opcode", o_opcode, 11'h010);
    chk("beq_imm", o_imm, 32'hFFFF_FFF8);
    chk("beq_pc", o_pc, 32'h100);
    chk("beq_rs2", o_rs2_addr, 2);

    // srai x1,x1,3
    i_pc = 32'h104; i_instr = 32'h4030_D093;
    step();
    chk("srai_opcode", o_opcode, 11'h002);
    chk("srai_alt", o_alt, 1);
    chk("srai_imm", o_imm, 32'h403);

    // sw x2,-4(x1), then funct3=011 store is illegal
    i_pc = 32'h108; i_instr = 32'hFE20_AE23;
    step();
    chk("sw_opcode", o_opcode, 11'h008);
    chk("sw_imm", o_imm, 32'hFFFF_FFFC);
    i_instr = 32'hFE20_BE23;
    step();
    chk("sd_exc", o_exception, 4'b0001);
    chk("sd_opcode", o_opcode, 0);

    i_instr = 32'hFFFF_FFFF;
    step();
    chk("ill_exc", o_exception, 4'b0001);
    chk("ill_opcode", o_opcode, 0);

    i_instr = 32'h3020_0073;
    step();
    chk("mret_exc", o_exception, 4'b1000);
    chk("mret_opcode", o_opcode, 11'h200);
    chk("mret_imm", o_imm, 0);

    i_instr = 32'h0000_0073;
    step();
    chk("ecall_exc", o_exception, 4'b0010);

    // Downstream stall freezes everything; flush is deferred until unstalled
    i_pc = 32'h200; i_instr = 32'h0050_0093;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_pc = 32'h300 + 32'(i * 4);
      i_instr = 32'h0000_A103 + 32'(i << 7);
      if (i == 2) flush = 1'b1;
      step();
      chk("stl_ce", o_ce, 1);
      chk("stl_pc", o_pc, 32'h200);
      chk("stl_imm", o_imm, 5);
    end
    stall = 1'b0;
    step();
    chk("flush_ce", o_ce, 0);
    flush = 1'b0;

    // Reset while a hazard is pending
    i_pc = 32'h400; i_instr = 32'h0000_A103;
    step();
    chk("rh_ce", o_ce, 1);
    i_instr = 32'h0011_01B3;
    #1;
    chk("rh_stall", o_stall_decode, 1);
    rst = 1'b1;
    step();
    chk("rr_ce", o_ce, 0);
    chk("rr_pc", o_pc, 0);
    chk("rr_opcode", o_opcode, 0);
    chk("rr_rd", o_rd_addr, 0);
    chk("rr_stall", o_stall_decode, 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
